// File: rtl/div4_vector_seq.sv
// Sequential 64/32 unsigned restoring divider on 16-bit limbs.
// One quotient bit per cycle; divide-by-zero and quotient overflow are reported in a single cycle.
module div4_vector_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y3,
  input  logic [15:0] y2,
  input  logic [15:0] y1,
  input  logic [15:0] y0,
  input  logic [15:0] b1,
  input  logic [15:0] b0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q1,
  output logic [15:0] q0,
  output logic [15:0] r1,
  output logic [15:0] r0,
  output logic        err_div0,
  output logic        err_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [32:0] p_reg, p_next;
  logic [31:0] s_reg, s_next;
  logic [31:0] quo_reg, quo_next;
  logic [31:0] b_reg, b_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] q_reg, q_next;
  logic [31:0] r_reg, r_next;
  logic        err_div0_reg, err_div0_next;
  logic        err_ovf_reg, err_ovf_next;

  logic [31:0] b_in;
  logic [31:0] y_hi;
  logic [32:0] t_step;
  logic [32:0] p_step;
  logic        q_bit;

  assign b_in = {b1, b0};
  assign y_hi = {y3, y2};

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    t_step = {p_reg[31:0], s_reg[31]};
    q_bit  = (t_step >= {1'b0, b_reg});
    p_step = q_bit ? (t_step - {1'b0, b_reg}) : t_step;
  end

  always_comb begin
    state_next    = state_reg;
    p_next        = p_reg;
    s_next        = s_reg;
    quo_next      = quo_reg;
    b_next        = b_reg;
    cnt_next      = cnt_reg;
    q_next        = q_reg;
    r_next        = r_reg;
    err_div0_next = err_div0_reg;
    err_ovf_next  = err_ovf_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          b_next = b_in;
          if (b_in == 32'd0) begin
            state_next    = DONE;
            err_div0_next = 1'b1;
            q_next        = 32'hFFFF_FFFF;
            r_next        = {y1, y0};
          end else if (y_hi >= b_in) begin
            // Upper half already >= divisor: the quotient cannot fit in 32 bits.
            state_next   = DONE;
            err_ovf_next = 1'b1;
            q_next       = 32'hFFFF_FFFF;
            r_next       = 32'd0;
          end else begin
            state_next = CALC;
            p_next     = {1'b0, y_hi};
            s_next     = {y1, y0};
            quo_next   = 32'd0;
            cnt_next   = 5'd0;
          end
        end
      end
      CALC: begin
        p_next   = p_step;
        s_next   = {s_reg[30:0], 1'b0};
        quo_next = {quo_reg[30:0], q_bit};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) begin
          state_next = DONE;
          q_next     = {quo_reg[30:0], q_bit};
          r_next     = p_step[31:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next    = IDLE;
          err_div0_next = 1'b0;
          err_ovf_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      p_reg        <= 33'd0;
      s_reg        <= 32'd0;
      quo_reg      <= 32'd0;
      b_reg        <= 32'd0;
      cnt_reg      <= 5'd0;
      q_reg        <= 32'd0;
      r_reg        <= 32'd0;
      err_div0_reg <= 1'b0;
      err_ovf_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      p_reg        <= p_next;
      s_reg        <= s_next;
      quo_reg      <= quo_next;
      b_reg        <= b_next;
      cnt_reg      <= cnt_next;
      q_reg        <= q_next;
      r_reg        <= r_next;
      err_div0_reg <= err_div0_next;
      err_ovf_reg  <= err_ovf_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign q1        = q_reg[31:16];
  assign q0        = q_reg[15:0];
  assign r1        = r_reg[31:16];
  assign r0        = r_reg[15:0];
  assign err_div0  = err_div0_reg;
  assign err_ovf   = err_ovf_reg;

endmodule

// File: tb/tb_div4_vector_seq.sv
// Directed bench for div4_vector_seq: hand-computed quotients, remainders, flags and latencies.
module tb_div4_vector_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y3, y2, y1, y0;
  logic [15:0] b1, b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q1, q0, r1, r0;
  logic        err_div0;
  logic        err_ovf;

  int total;
  int bad;

  div4_vector_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y3       (y3),
    .y2       (y2),
    .y1       (y1),
    .y0       (y0),
    .b1       (b1),
    .b0       (b0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q1       (q1),
    .q0       (q0),
    .r1       (r1),
    .r0       (r0),
    .err_div0 (err_div0),
    .err_ovf  (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands, handshake on one edge, and return edges after accept until out_valid.
  task automatic start_div(input logic [63:0] d, input logic [31:0] b, output int lat);
    @(negedge clk);
    chk("in_ready_before", {63'd0, in_ready}, 64'd1);
    {y3, y2, y1, y0} = d;
    {b1, b0} = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [63:0] d, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ediv0, input logic eovf, input int elat);
    int lat;
    start_div(d, b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_q"}, {32'd0, q1, q0}, {32'd0, eq});
    chk({tag, "_r"}, {32'd0, r1, r0}, {32'd0, er});
    chk({tag, "_flags"}, {62'd0, err_div0, err_ovf}, {62'd0, ediv0, eovf});
    $display("div %s: D=0x%016h B=0x%08h q=0x%04h%04h r=0x%04h%04h div0=%0b ovf=%0b lat=%0d",
             tag, d, b, q1, q0, r1, r0, err_div0, err_ovf, lat);
  endtask

  task automatic release_result(input string tag, input logic [31:0] eq, input logic [31:0] er);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rel_ready"}, {62'd0, in_ready, out_valid}, 64'b10);
    chk({tag, "_rel_flags"}, {62'd0, err_div0, err_ovf}, 64'd0);
    chk({tag, "_rel_hold"}, {q1, q0, r1, r0}, {eq, er});
  endtask

  initial begin
    int lat;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    {y3, y2, y1, y0} = 64'd0;
    {b1, b0} = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hs", {62'd0, in_ready, out_valid}, 64'b10);
    chk("reset_qr", {q1, q0, r1, r0}, 64'd0);
    chk("reset_flags", {62'd0, err_div0, err_ovf}, 64'd0);
    rst_n = 1'b1;

    run_div("small", 64'h0000_0000_0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 1'b0, 1'b0, 32);
    release_result("small", 32'h0000_000E, 32'h0000_0002);
    run_div("maxrt", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32);
    release_result("maxrt", 32'hFFFF_FFFF, 32'h0);
    run_div("edge", 64'h0000_0001_0000_0000, 32'h0000_0002, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32);
    release_result("edge", 32'h8000_0000, 32'h0);
    run_div("div0", 64'h1234_5678_9ABC_DEF0, 32'h0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 0);
    release_result("div0", 32'hFFFF_FFFF, 32'h9ABC_DEF0);
    run_div("ovf", 64'h0001_0000_0000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 0);
    release_result("ovf", 32'hFFFF_FFFF, 32'h0);
    run_div("shift16", 64'h0000_1234_5678_9ABC, 32'h0001_0000, 32'h1234_5678, 32'h0000_9ABC, 1'b0, 1'b0, 32);
    release_result("shift16", 32'h1234_5678, 32'h0000_9ABC);
    run_div("rem15", 64'h0000_0000_FFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0, 32);

    // Backpressure: result held while out_ready stays low, new requests ignored.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      {y3, y2, y1, y0} = 64'h0000_0000_0000_0009;
      {b1, b0} = 32'h0000_0003;
      chk("bp_hs", {62'd0, in_ready, out_valid}, 64'b01);
      chk("bp_hold", {q1, q0, r1, r0}, {32'h0FFF_FFFF, 32'h0000_000F});
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("rem15", 32'h0FFF_FFFF, 32'h0000_000F);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    {y3, y2, y1, y0} = 64'h0000_0000_0000_0064;
    {b1, b0} = 32'h0000_0007;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("mid_calc_busy", {62'd0, in_ready, out_valid}, 64'b00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_hs", {62'd0, in_ready, out_valid}, 64'b10);
    chk("midrst_qr", {q1, q0, r1, r0}, 64'd0);
    chk("midrst_flags", {62'd0, err_div0, err_ovf}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_idle", {62'd0, in_ready, out_valid}, 64'b10);

    run_div("after_rst", 64'h0000_0000_0000_03E8, 32'h0000_0021, 32'h0000_001E, 32'h0000_000A, 1'b0, 1'b0, 32);
    release_result("after_rst", 32'h0000_001E, 32'h0000_000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
